// File: rtl/axim_ctrl_responder.sv
// Memory-backed responder for a control-driven stream master: a read FSM
// streams words out of a local array and a write FSM accepts words into it.
module axim_ctrl_responder #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int MEM_WORDS          = 4096
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_raddr_offset_i,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_rxfer_size_i,
  input  logic                          ctrl_rstart_i,
  output logic                          ctrl_rdone_o,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rd_tdata_o,
  output logic                          rd_tvalid_o,
  input  logic                          rd_tready_i,
  output logic                          rd_tlast_o,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_waddr_offset_i,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_wxfer_size_i,
  input  logic                          ctrl_wstart_i,
  output logic                          ctrl_wdone_o,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] wr_tdata_i,
  input  logic                          wr_tvalid_i,
  output logic                          wr_tready_o,
  output logic [1:0]                    rd_state,
  output logic [1:0]                    wr_state
);
  // Stream handshake: a beat transfers on a rising edge where valid and ready
  // are both high; valid never waits on ready, and an offered beat (data,
  // last, valid) holds unchanged until it is accepted.

  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = C_XFER_SIZE_WIDTH - 2;
  localparam logic [IW-1:0]                IDX_ONE  = 1;
  localparam logic [CW-1:0]                REM_ONE  = 1;
  localparam logic [C_XFER_SIZE_WIDTH-1:0] SIZE_ONE = 1;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_STREAM = 2'd1, R_DONE = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACCEPT = 2'd1, W_DONE = 2'd2} wr_state_t;

  logic [C_M_AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  rd_state_t r_state;
  wr_state_t w_state;
  logic [IW-1:0] r_idx, w_idx, r_start_idx, w_start_idx;
  // Remaining-beats counters hold (beats - 1) so a 2^30-beat transfer fits.
  logic [CW-1:0] r_rem, w_rem, r_start_rem, w_start_rem;
  logic [C_XFER_SIZE_WIDTH-1:0] r_size_m1, w_size_m1;
  logic wr_fire;
  logic unused_bits;

  assign r_start_idx = ctrl_raddr_offset_i[IW+1:2];
  assign w_start_idx = ctrl_waddr_offset_i[IW+1:2];
  assign r_size_m1   = ctrl_rxfer_size_i - SIZE_ONE;
  assign w_size_m1   = ctrl_wxfer_size_i - SIZE_ONE;
  assign r_start_rem = r_size_m1[C_XFER_SIZE_WIDTH-1:2];
  assign w_start_rem = w_size_m1[C_XFER_SIZE_WIDTH-1:2];
  assign wr_fire     = wr_tready_o && wr_tvalid_i;
  assign rd_state    = r_state;
  assign wr_state    = w_state;
  assign unused_bits = ^{ctrl_raddr_offset_i, ctrl_waddr_offset_i, r_size_m1[1:0], w_size_m1[1:0]};

  // Storage is deliberately left out of reset so aborted transfers keep data.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[w_idx] <= wr_tdata_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= R_IDLE;
      r_idx        <= '0;
      r_rem        <= '0;
      rd_tdata_o   <= '0;
      rd_tvalid_o  <= 1'b0;
      rd_tlast_o   <= 1'b0;
      ctrl_rdone_o <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ctrl_rstart_i) begin
            if (ctrl_rxfer_size_i == '0) begin
              r_state      <= R_DONE;
              ctrl_rdone_o <= 1'b1;
            end else begin
              r_state     <= R_STREAM;
              rd_tvalid_o <= 1'b1;
              rd_tdata_o  <= mem[r_start_idx];
              rd_tlast_o  <= (r_start_rem == '0);
              r_idx       <= r_start_idx + IDX_ONE;
              r_rem       <= r_start_rem;
            end
          end
        end
        R_STREAM: begin
          if (rd_tready_i) begin
            if (r_rem == '0) begin
              r_state      <= R_DONE;
              rd_tvalid_o  <= 1'b0;
              rd_tlast_o   <= 1'b0;
              rd_tdata_o   <= '0;
              ctrl_rdone_o <= 1'b1;
            end else begin
              // Next word loads on the accepting edge: no bubble between beats.
              rd_tdata_o <= mem[r_idx];
              rd_tlast_o <= (r_rem == REM_ONE);
              r_idx      <= r_idx + IDX_ONE;
              r_rem      <= r_rem - REM_ONE;
            end
          end
        end
        R_DONE: begin
          ctrl_rdone_o <= 1'b0;
          r_state      <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state      <= W_IDLE;
      w_idx        <= '0;
      w_rem        <= '0;
      wr_tready_o  <= 1'b0;
      ctrl_wdone_o <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (ctrl_wstart_i) begin
            w_idx <= w_start_idx;
            w_rem <= w_start_rem;
            if (ctrl_wxfer_size_i == '0) begin
              w_state      <= W_DONE;
              ctrl_wdone_o <= 1'b1;
            end else begin
              w_state     <= W_ACCEPT;
              wr_tready_o <= 1'b1;
            end
          end
        end
        W_ACCEPT: begin
          if (wr_tvalid_i) begin
            w_idx <= w_idx + IDX_ONE;
            if (w_rem == '0) begin
              w_state      <= W_DONE;
              wr_tready_o  <= 1'b0;
              ctrl_wdone_o <= 1'b1;
            end else begin
              w_rem <= w_rem - REM_ONE;
            end
          end
        end
        W_DONE: begin
          ctrl_wdone_o <= 1'b0;
          w_state      <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axim_ctrl_responder.sv
// Directed bench for axim_ctrl_responder: writes known patterns, reads them
// back through the stream port and scores every beat against a queue.
module tb_axim_ctrl_responder;
  logic        clk;
  logic        rstn;
  logic [31:0] ctrl_raddr_offset_i;
  logic [31:0] ctrl_rxfer_size_i;
  logic        ctrl_rstart_i;
  logic        ctrl_rdone_o;
  logic [31:0] rd_tdata_o;
  logic        rd_tvalid_o;
  logic        rd_tready_i;
  logic        rd_tlast_o;
  logic [31:0] ctrl_waddr_offset_i;
  logic [31:0] ctrl_wxfer_size_i;
  logic        ctrl_wstart_i;
  logic        ctrl_wdone_o;
  logic [31:0] wr_tdata_i;
  logic        wr_tvalid_i;
  logic        wr_tready_o;
  logic [1:0]  rd_state;
  logic [1:0]  wr_state;

  axim_ctrl_responder dut (
    .clk                 (clk),
    .rstn                (rstn),
    .ctrl_raddr_offset_i (ctrl_raddr_offset_i),
    .ctrl_rxfer_size_i   (ctrl_rxfer_size_i),
    .ctrl_rstart_i       (ctrl_rstart_i),
    .ctrl_rdone_o        (ctrl_rdone_o),
    .rd_tdata_o          (rd_tdata_o),
    .rd_tvalid_o         (rd_tvalid_o),
    .rd_tready_i         (rd_tready_i),
    .rd_tlast_o          (rd_tlast_o),
    .ctrl_waddr_offset_i (ctrl_waddr_offset_i),
    .ctrl_wxfer_size_i   (ctrl_wxfer_size_i),
    .ctrl_wstart_i       (ctrl_wstart_i),
    .ctrl_wdone_o        (ctrl_wdone_o),
    .wr_tdata_i          (wr_tdata_i),
    .wr_tvalid_i         (wr_tvalid_i),
    .wr_tready_o         (wr_tready_o),
    .rd_state            (rd_state),
    .wr_state            (wr_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];      // {tlast, data} per expected read beat
  int compared = 0;
  int mismatched = 0;
  int rd_beats = 0;
  int rdone_cnt = 0;
  int wdone_cnt = 0;
  int wr_ready_cycles = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("rd_hold", {31'b0, rd_tvalid_o, rd_tlast_o, rd_tdata_o}, {31'b0, 1'b1, prev_last, prev_data});
      if (rd_tvalid_o && rd_tready_i) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL rd_unexpected_beat: got data 0x%0h last %0b, expected no beat", rd_tdata_o, rd_tlast_o);
        end else begin
          check("rd_beat", {31'b0, rd_tlast_o, rd_tdata_o}, {31'b0, exp_q.pop_front()});
        end
        rd_beats++;
      end
      stall_prev = rd_tvalid_o && !rd_tready_i;
      prev_data  = rd_tdata_o;
      prev_last  = rd_tlast_o;
      if (ctrl_rdone_o) rdone_cnt++;
      if (ctrl_wdone_o) wdone_cnt++;
      if (wr_tready_o) wr_ready_cycles++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [31:0] off, input logic [31:0] size,
                          input logic [31:0] base, input int nbeats);
    int k = 0;
    int guard = 0;
    int w0 = wdone_cnt;
    int r0 = wr_ready_cycles;
    logic hs;
    @(posedge clk); #1;
    ctrl_waddr_offset_i = off;
    ctrl_wxfer_size_i   = size;
    ctrl_wstart_i       = 1'b1;
    @(posedge clk); #1;
    ctrl_wstart_i = 1'b0;
    while (k < nbeats && guard < 200) begin
      wr_tdata_i  = base + k;
      wr_tvalid_i = 1'b1;
      @(negedge clk);
      hs = wr_tready_o;
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    wr_tvalid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wr_beats", k, nbeats);
    check("wr_done_pulses", wdone_cnt - w0, 1);
    check("wr_ready_cycles", wr_ready_cycles - r0, nbeats);
  endtask

  task automatic do_read(input logic [31:0] off, input logic [31:0] size, input int nbeats,
                         input bit rand_ready, input bit restart_mid);
    int b0 = rd_beats;
    int d0 = rdone_cnt;
    int guard = 0;
    bit restarted = 1'b0;
    @(posedge clk); #1;
    ctrl_raddr_offset_i = off;
    ctrl_rxfer_size_i   = size;
    ctrl_rstart_i       = 1'b1;
    rd_tready_i         = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    ctrl_rstart_i = 1'b0;
    while (rd_beats - b0 < nbeats && guard < 400) begin
      if (restart_mid && !restarted && rd_beats - b0 == 2) begin
        // A strobe mid-stream with a different request must be dropped.
        ctrl_raddr_offset_i = 32'h0;
        ctrl_rxfer_size_i   = 32'h40;
        ctrl_rstart_i       = 1'b1;
        restarted           = 1'b1;
      end else begin
        ctrl_rstart_i = 1'b0;
      end
      rd_tready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    ctrl_rstart_i = 1'b0;
    rd_tready_i   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rd_beat_count", rd_beats - b0, nbeats);
    check("rd_done_pulses", rdone_cnt - d0, 1);
    check("rd_queue_drained", exp_q.size(), 0);
    check("rd_state_idle", rd_state, 2'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b0, d0, guard;
    rstn = 1'b0;
    ctrl_raddr_offset_i = '0; ctrl_rxfer_size_i = '0; ctrl_rstart_i = 1'b0;
    rd_tready_i = 1'b0;
    ctrl_waddr_offset_i = '0; ctrl_wxfer_size_i = '0; ctrl_wstart_i = 1'b0;
    wr_tdata_i = '0; wr_tvalid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {rd_tvalid_o, rd_tlast_o, ctrl_rdone_o, ctrl_wdone_o, wr_tready_o}, 5'b0);
    check("reset_rdata", rd_tdata_o, 32'h0);
    check("reset_states", {rd_state, wr_state}, 4'b0);
    rstn = 1'b1;

    // 16 words at byte 0x100 -> mem[0x40..0x4F] = C0DE0000 + k
    do_write(32'h100, 32'h40, 32'hC0DE_0000, 16);
    for (int k = 0; k < 16; k++) exp_q.push_back({k == 15, 32'hC0DE_0000 + k});
    do_read(32'h100, 32'h40, 16, 1'b1, 1'b0);

    // Wrap: byte 0x3FFC is word 4095; second word lands in mem[0]
    do_write(32'h3FFC, 32'h8, 32'hBEEF_0000, 2);
    exp_q.push_back({1'b0, 32'hBEEF_0000});
    exp_q.push_back({1'b1, 32'hBEEF_0001});
    do_read(32'h3FFE, 32'h6, 2, 1'b0, 1'b0);

    // 29 bytes round up to 8 beats at word 0x80
    do_write(32'h200, 32'h1D, 32'h1234_0000, 8);
    for (int k = 0; k < 8; k++) exp_q.push_back({k == 7, 32'h1234_0000 + k});
    do_read(32'h200, 32'h20, 8, 1'b1, 1'b1);

    // Zero-size write: done pulse, never ready
    do_write(32'h300, 32'h0, 32'h0, 0);

    // Zero-size read: no beat, done in the cycle after the sampling edge
    d0 = rdone_cnt;
    b0 = rd_beats;
    @(posedge clk); #1;
    ctrl_raddr_offset_i = 32'h100; ctrl_rxfer_size_i = 32'h0; ctrl_rstart_i = 1'b1;
    rd_tready_i = 1'b1;
    @(posedge clk); #1;
    ctrl_rstart_i = 1'b0;
    @(negedge clk);
    check("rd0_done_high", {ctrl_rdone_o, rd_tvalid_o}, 2'b10);
    @(negedge clk);
    check("rd0_done_low", {ctrl_rdone_o, rd_tvalid_o}, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rd_tready_i = 1'b0;
    check("rd0_pulses", rdone_cnt - d0, 1);
    check("rd0_no_beats", rd_beats - b0, 0);

    // Reset after beat 3 of 8: outputs clear at once, no done pulse
    d0 = rdone_cnt;
    b0 = rd_beats;
    for (int k = 0; k < 8; k++) exp_q.push_back({k == 7, 32'h1234_0000 + k});
    @(posedge clk); #1;
    ctrl_raddr_offset_i = 32'h200; ctrl_rxfer_size_i = 32'h20; ctrl_rstart_i = 1'b1;
    rd_tready_i = 1'b1;
    @(posedge clk); #1;
    ctrl_rstart_i = 1'b0;
    guard = 0;
    while (rd_beats - b0 < 3 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    rstn = 1'b0;
    rd_tready_i = 1'b0;
    #1;
    check("abort_beats", rd_beats - b0, 3);
    check("abort_ctrl", {rd_tvalid_o, rd_tlast_o, ctrl_rdone_o, wr_tready_o}, 4'b0);
    check("abort_rdata", rd_tdata_o, 32'h0);
    check("abort_state", rd_state, 2'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", rdone_cnt - d0, 0);

    // Memory survives reset; read words 0x41..0x42
    exp_q.push_back({1'b0, 32'hC0DE_0001});
    exp_q.push_back({1'b1, 32'hC0DE_0002});
    do_read(32'h104, 32'h8, 2, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
